// File: rtl/macro_pkg.sv
// Shared encodings, state/kind enums and the uop formatter for macro_uop_sequencer.
package macro_pkg;

  localparam logic [6:0]  MACRO_OPCODE  = 7'b1110111;
  localparam logic [6:0]  FUNCT7_MACRO  = 7'b1011111;
  localparam logic [2:0]  FUNCT3_REGSUM = 3'b111;
  localparam logic [2:0]  FUNCT3_REGCLR = 3'b110;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [6:0]  OP_REG        = 7'b0110011;
  localparam logic [6:0]  OP_IMM        = 7'b0010011;

  typedef enum logic {IDLE, EXPAND} state_e;

  typedef enum logic [1:0] {MK_NONE, MK_SUM, MK_CLR} macro_kind_e;

  // REGSUM emits ADD rd, src_a, src_b; REGCLR emits ADDI src_b, x0, 0.
  function automatic logic [31:0] fmt_uop(input macro_kind_e kind,
                                          input logic [4:0]  rd,
                                          input logic [4:0]  src_a,
                                          input logic [4:0]  src_b);
    logic [31:0] uop;
    case (kind)
      MK_SUM:  uop = {7'b0, src_b, src_a, 3'b000, rd, OP_REG};
      MK_CLR:  uop = {12'b0, 5'b0, 3'b000, src_b, OP_IMM};
      default: uop = NOP_INSTR;
    endcase
    return uop;
  endfunction

endpackage

// File: rtl/macro_decode.sv
// Combinational macro classifier; REGCLR is recognised only when
// MACRO_UOP_SEQ_CLR_EN is defined.
module macro_decode
  import macro_pkg::*;
(
  input  logic [31:0] instr_in,
  output macro_kind_e kind,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        range_ok
);

  logic is_macro;

  always_comb begin
    rd       = instr_in[11:7];
    rs1      = instr_in[19:15];
    rs2      = instr_in[24:20];
    range_ok = (instr_in[19:15] <= instr_in[24:20]);
    is_macro = (instr_in[6:0] == MACRO_OPCODE) && (instr_in[31:25] == FUNCT7_MACRO);
    kind     = MK_NONE;
    if (is_macro && (instr_in[14:12] == FUNCT3_REGSUM)) begin
      kind = MK_SUM;
    end
`ifdef MACRO_UOP_SEQ_CLR_EN
    else if (is_macro && (instr_in[14:12] == FUNCT3_REGCLR)) begin
      kind = MK_CLR;
    end
`else
    else begin
      kind = MK_NONE;
    end
`endif
  end

endmodule

// File: rtl/macro_uop_sequencer.sv
// Fetch-to-decode sequencer expanding REGSUM (and REGCLR under
// MACRO_UOP_SEQ_CLR_EN) macros into base RV32I uops; others pass through.
module macro_uop_sequencer
  import macro_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        instr_valid_in,
  input  logic        flush,
  input  logic        dec_ready,
  output logic [31:0] uop_out,
  output logic        uop_valid,
  output logic        fetch_stall,
  output logic        busy,
  output logic [4:0]  seq_idx
);

  macro_kind_e dec_kind;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_range_ok;

  macro_decode u_decode (
    .instr_in (instr_in),
    .kind     (dec_kind),
    .rd       (dec_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .range_ok (dec_range_ok)
  );

  state_e      state_q, state_d;
  macro_kind_e kind_q, kind_d;
  logic [31:0] uop_q, uop_d;
  logic        valid_q, valid_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic        advance;
  logic [4:0]  next_reg;

  assign advance  = ~valid_q | dec_ready;
  // Cannot exceed rs2, so the 5-bit sum never wraps.
  assign next_reg = rs1_q + idx_q + 5'd1;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    uop_d   = uop_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      idx_d   = 5'd0;
    end else if (advance) begin
      case (state_q)
        IDLE: begin
          if (!instr_valid_in) begin
            valid_d = 1'b0;
          end else if (dec_kind == MK_NONE) begin
            uop_d   = instr_in;
            valid_d = 1'b1;
          end else if (dec_range_ok) begin
            kind_d  = dec_kind;
            rd_d    = dec_rd;
            rs1_d   = dec_rs1;
            rs2_d   = dec_rs2;
            idx_d   = 5'd0;
            uop_d   = fmt_uop(dec_kind, dec_rd, 5'd0, dec_rs1);
            valid_d = 1'b1;
            state_d = (dec_rs1 != dec_rs2) ? EXPAND : IDLE;
          end else begin
            uop_d   = NOP_INSTR;
            valid_d = 1'b1;
          end
        end
        EXPAND: begin
          idx_d   = idx_q + 5'd1;
          uop_d   = fmt_uop(kind_q, rd_q, rd_q, next_reg);
          valid_d = 1'b1;
          if (next_reg == rs2_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= MK_NONE;
      uop_q   <= NOP_INSTR;
      valid_q <= 1'b0;
      idx_q   <= 5'd0;
      rd_q    <= 5'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      uop_q   <= uop_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign uop_out     = uop_q;
  assign uop_valid   = valid_q;
  assign busy        = (state_q == EXPAND);
  assign fetch_stall = (state_q == EXPAND) | ~advance;
  assign seq_idx     = idx_q;

endmodule
